// File: rtl/memory_pkg.sv
// Memory subsystem shared definitions.
// Provides the status codes returned on the response path, the TLB control
// states, the reference TLB line layout, the default TLB depth and a helper
// that derives the page-offset width from the page size.
package memory_pkg;

  // Response status codes, 4 bits wide on the wire
  typedef enum logic [3:0] {
    MEM_OK         = 4'h0,
    MEM_ERR_ADDR   = 4'h1,
    MEM_ERR_ACCESS = 4'h2
  } mem_status_e;

  typedef enum logic [0:0] {
    TLB_IDLE  = 1'b0,
    TLB_FLUSH = 1'b1
  } tlb_state_e;

  localparam int TLB_ENTRIES_DEFAULT = 8;

  // Line layout at the default geometry (32-bit VA, 28-bit PA, 4 KiB pages)
  localparam int TLB_VPN_W_DEFAULT = 20;
  localparam int TLB_PPN_W_DEFAULT = 16;

  typedef struct packed {
    logic                         valid;
    logic                         wr_perm;
    logic [TLB_VPN_W_DEFAULT-1:0] vpn;
    logic [TLB_PPN_W_DEFAULT-1:0] ppn;
  } tlb_line_t;

  // Width of the in-page byte offset for a power-of-two page size
  function automatic int page_off_w(input int page_size);
    return $clog2(page_size);
  endfunction

endpackage

// File: rtl/mem_tlb_match.sv
// Combinational CAM compare for the TLB.
// Ports:
//   valid    - per-entry valid bits
//   vpns     - all entry VPNs, entry i at [i*VPN_W +: VPN_W]
//   key      - VPN to search for
//   hit      - a valid entry holds key
//   hit_idx  - index of that entry (at most one can match)
//   free     - at least one entry is invalid
//   free_idx - lowest-index invalid entry
module mem_tlb_match
  import memory_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES_DEFAULT,
  parameter int VPN_W   = TLB_VPN_W_DEFAULT,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]       valid,
  input  logic [ENTRIES*VPN_W-1:0] vpns,
  input  logic [VPN_W-1:0]         key,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx,
  output logic                     free,
  output logic [IDX_W-1:0]         free_idx
);

  // Parallel compare of the key against every valid entry
  always_comb begin
    hit     = 1'b0;
    hit_idx = {IDX_W{1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (vpns[i*VPN_W +: VPN_W] == key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end else begin
        hit     = hit;
      end
    end
  end

  // Priority encoder: scanning downwards lets the lowest invalid index win
  always_comb begin
    free     = 1'b0;
    free_idx = {IDX_W{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end else begin
        free     = free;
      end
    end
  end

endmodule

// File: rtl/mem_tlb.sv
// Fully associative translation lookaside buffer.
// Translates virtual addresses to physical addresses through VPN->PPN page
// mappings. Loads overwrite an existing mapping of the same VPN, otherwise
// fill the lowest free entry, otherwise evict round-robin. A flush walks the
// table one entry per cycle and pulses flush_done when finished.
//
// Optional feature (compile-time macro MEM_TLB_PERM_EN): per-entry write
// permission; a write lookup hitting a read-only page returns MEM_ERR_ACCESS.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   lk_valid/lk_ready   - lookup handshake; lk_vaddr, lk_write request fields
//   rsp_valid/rsp_ready - response handshake; rsp_paddr, rsp_status, rsp_hit
//   ld_valid/ld_ready   - load handshake; ld_vpn, ld_ppn, ld_wr_perm
//   flush_valid         - start a flush (only sampled when idle)
//   flush_done          - one-cycle pulse at flush completion
//   occupancy           - number of valid entries
module mem_tlb
  import memory_pkg::*;
#(
  parameter int VIRT_ADDR_WIDTH = 32,
  parameter int PHYS_ADDR_WIDTH = 28,
  parameter int PAGE_SIZE       = 4096,
  parameter int TLB_ENTRIES     = TLB_ENTRIES_DEFAULT,
  localparam int OFF_W = page_off_w(PAGE_SIZE),
  localparam int VPN_W = VIRT_ADDR_WIDTH - OFF_W,
  localparam int PPN_W = PHYS_ADDR_WIDTH - OFF_W,
  localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lk_valid,
  output logic                       lk_ready,
  input  logic [VIRT_ADDR_WIDTH-1:0] lk_vaddr,
  input  logic                       lk_write,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [PHYS_ADDR_WIDTH-1:0] rsp_paddr,
  output mem_status_e                rsp_status,
  output logic                       rsp_hit,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [VPN_W-1:0]           ld_vpn,
  input  logic [PPN_W-1:0]           ld_ppn,
  input  logic                       ld_wr_perm,
  input  logic                       flush_valid,
  output logic                       flush_done,
  output logic [IDX_W:0]             occupancy
);

  tlb_state_e                 state_r, state_nxt_s;
  logic [IDX_W-1:0]           flush_idx_r;
  logic [IDX_W-1:0]           victim_r;
  logic [IDX_W:0]             occupancy_r;
  logic                       flush_done_r;
  logic [TLB_ENTRIES-1:0]     valid_r;
  logic [VPN_W-1:0]           vpn_r [TLB_ENTRIES];
  logic [PPN_W-1:0]           ppn_r [TLB_ENTRIES];
  logic [TLB_ENTRIES*VPN_W-1:0] vpn_flat_s;

  logic                       rsp_valid_r;
  logic [PHYS_ADDR_WIDTH-1:0] rsp_paddr_r;
  mem_status_e                rsp_status_r;
  logic                       rsp_hit_r;

  logic                       idle_s, flush_last_s;
  logic                       lk_fire_s, ld_fire_s;
  logic                       lk_hit_s, lk_free_unused_s;
  logic [IDX_W-1:0]           lk_hit_idx_s, lk_free_idx_unused_s;
  logic                       ld_hit_s, ld_free_s;
  logic [IDX_W-1:0]           ld_hit_idx_s, ld_free_idx_s, ld_idx_s;
  logic                       deny_s;
  logic [PHYS_ADDR_WIDTH-1:0] lk_paddr_s;
  mem_status_e                lk_status_s;
  logic                       unused_lk_free_s;

  assign idle_s    = (state_r == TLB_IDLE);
  assign lk_ready  = idle_s && !flush_valid && (!rsp_valid_r || rsp_ready);
  assign ld_ready  = idle_s && !flush_valid;
  assign lk_fire_s = lk_valid && lk_ready;
  assign ld_fire_s = ld_valid && ld_ready;

  // The lookup CAM only needs the hit result
  assign unused_lk_free_s = lk_free_unused_s ^ (^lk_free_idx_unused_s);

  // Flatten the VPN storage for the compare units
  always_comb begin
    vpn_flat_s = {(TLB_ENTRIES*VPN_W){1'b0}};
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      vpn_flat_s[i*VPN_W +: VPN_W] = vpn_r[i];
    end
  end

  mem_tlb_match #(.ENTRIES(TLB_ENTRIES), .VPN_W(VPN_W)) u_lk_match (
    .valid    (valid_r),
    .vpns     (vpn_flat_s),
    .key      (lk_vaddr[VIRT_ADDR_WIDTH-1:OFF_W]),
    .hit      (lk_hit_s),
    .hit_idx  (lk_hit_idx_s),
    .free     (lk_free_unused_s),
    .free_idx (lk_free_idx_unused_s)
  );

  // Separate compare for loads so a same-cycle lookup sees pre-load contents
  mem_tlb_match #(.ENTRIES(TLB_ENTRIES), .VPN_W(VPN_W)) u_ld_match (
    .valid    (valid_r),
    .vpns     (vpn_flat_s),
    .key      (ld_vpn),
    .hit      (ld_hit_s),
    .hit_idx  (ld_hit_idx_s),
    .free     (ld_free_s),
    .free_idx (ld_free_idx_s)
  );

  // Load target: existing mapping, else lowest free slot, else the victim
  always_comb begin
    ld_idx_s = victim_r;
    if (ld_hit_s) begin
      ld_idx_s = ld_hit_idx_s;
    end else if (ld_free_s) begin
      ld_idx_s = ld_free_idx_s;
    end else begin
      ld_idx_s = victim_r;
    end
  end

`ifdef MEM_TLB_PERM_EN
  logic perm_r [TLB_ENTRIES];

  // Write-permission storage, written alongside the mapping
  always_ff @(posedge clk) begin
    if (ld_fire_s) begin
      perm_r[ld_idx_s] <= ld_wr_perm;
    end
  end

  assign deny_s = lk_write && !perm_r[lk_hit_idx_s];
`else
  logic unused_perm_s;
  assign unused_perm_s = ld_wr_perm ^ lk_write;
  assign deny_s        = 1'b0;
`endif

  // Translation result for the current lookup request
  always_comb begin
    lk_status_s = MEM_ERR_ADDR;
    lk_paddr_s  = {PHYS_ADDR_WIDTH{1'b0}};
    if (lk_hit_s) begin
      if (deny_s) begin
        lk_status_s = MEM_ERR_ACCESS;
        lk_paddr_s  = {PHYS_ADDR_WIDTH{1'b0}};
      end else begin
        lk_status_s = MEM_OK;
        lk_paddr_s  = {ppn_r[lk_hit_idx_s], lk_vaddr[OFF_W-1:0]};
      end
    end else begin
      lk_status_s = MEM_ERR_ADDR;
      lk_paddr_s  = {PHYS_ADDR_WIDTH{1'b0}};
    end
  end

  // Next-state logic; the last flush step is the one at the top index
  always_comb begin
    state_nxt_s  = state_r;
    flush_last_s = 1'b0;
    case (state_r)
      TLB_IDLE: begin
        if (flush_valid) begin
          state_nxt_s = TLB_FLUSH;
        end else begin
          state_nxt_s = TLB_IDLE;
        end
      end
      TLB_FLUSH: begin
        if (&flush_idx_r) begin
          state_nxt_s  = TLB_IDLE;
          flush_last_s = 1'b1;
        end else begin
          state_nxt_s  = TLB_FLUSH;
        end
      end
      default: begin
        state_nxt_s = TLB_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= TLB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entry valid bits, occupancy, victim pointer and flush walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r      <= {TLB_ENTRIES{1'b0}};
      occupancy_r  <= {(IDX_W+1){1'b0}};
      victim_r     <= {IDX_W{1'b0}};
      flush_idx_r  <= {IDX_W{1'b0}};
      flush_done_r <= 1'b0;
    end else begin
      flush_done_r <= flush_last_s;
      if (state_r == TLB_FLUSH) begin
        valid_r[flush_idx_r] <= 1'b0;
        if (valid_r[flush_idx_r]) begin
          occupancy_r <= occupancy_r - (IDX_W+1)'(1);
        end
        // Wraps back to 0 on the final step
        flush_idx_r <= flush_idx_r + IDX_W'(1);
      end else if (ld_fire_s) begin
        valid_r[ld_idx_s] <= 1'b1;
        if (!ld_hit_s && ld_free_s) begin
          occupancy_r <= occupancy_r + (IDX_W+1)'(1);
        end
        if (!ld_hit_s && !ld_free_s) begin
          victim_r <= victim_r + IDX_W'(1);
        end
      end
    end
  end

  // Mapping payload; only meaningful where the valid bit is set
  always_ff @(posedge clk) begin
    if (ld_fire_s) begin
      vpn_r[ld_idx_s] <= ld_vpn;
      ppn_r[ld_idx_s] <= ld_ppn;
    end
  end

  // Response register: load on accept, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r  <= 1'b0;
      rsp_paddr_r  <= {PHYS_ADDR_WIDTH{1'b0}};
      rsp_status_r <= MEM_OK;
      rsp_hit_r    <= 1'b0;
    end else if (lk_fire_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_paddr_r  <= lk_paddr_s;
      rsp_status_r <= lk_status_s;
      rsp_hit_r    <= lk_hit_s;
    end else if (rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_paddr  = rsp_paddr_r;
  assign rsp_status = rsp_status_r;
  assign rsp_hit    = rsp_hit_r;
  assign flush_done = flush_done_r;
  assign occupancy  = occupancy_r;

endmodule

// File: doc/mem_tlb.md
Name: mem_tlb

Overview:
- Parametrised, fully associative translation lookaside buffer for the memory subsystem; successor to the single-entry tlb_entry_t scheme.
- Translates a virtual address to a physical address using VPN→PPN page mappings.
- Supports configurable entry count, entry load with duplicate detection, round-robin replacement, and a multi-cycle flush.
- Sits between the request front-end and the physical memory array; status codes are mem_status_e.

Parameters:
- VIRT_ADDR_WIDTH, 32, virtual address width.
- PHYS_ADDR_WIDTH, 28, physical address width.
- PAGE_SIZE, 4096, page size in bytes; power of two. OFF_W = $clog2(PAGE_SIZE).
- TLB_ENTRIES, 8, number of entries; power of two, ≥2.
- Derived: VPN_W = VIRT_ADDR_WIDTH-OFF_W; PPN_W = PHYS_ADDR_WIDTH-OFF_W; IDX_W = $clog2(TLB_ENTRIES).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
lk_valid  in  1  lookup request valid
lk_ready  out  1  lookup accepted when lk_valid&&lk_ready
lk_vaddr  in  VIRT_ADDR_WIDTH  virtual address to translate
lk_write  in  1  lookup is for a write access
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumer ready
rsp_paddr  out  PHYS_ADDR_WIDTH  translated address; 0 on any error
rsp_status  out  4  mem_status_e: MEM_OK / MEM_ERR_ADDR / MEM_ERR_ACCESS
rsp_hit  out  1  VPN matched a valid entry
ld_valid  in  1  entry load request
ld_ready  out  1  load accepted when ld_valid&&ld_ready
ld_vpn  in  VPN_W  virtual page number to map
ld_ppn  in  PPN_W  physical page number
ld_wr_perm  in  1  write permission; used only with the optional feature
flush_valid  in  1  flush request
flush_done  out  1  one-cycle pulse when flush completes
occupancy  out  IDX_W+1  count of valid entries

Behaviour:
- Reset (async, rst=1) clears:
  - all entry valid bits, victim pointer and flush index to 0, and state to IDLE;
  - rsp_valid, rsp_paddr, rsp_hit, flush_done, occupancy to 0, and rsp_status to MEM_OK.
- Reset asserted mid-flush aborts the flush; flush_done is not pulsed.
- States: IDLE, FLUSH.
  - IDLE→FLUSH when flush_valid=1 in IDLE.
  - FLUSH clears entry[flush_idx] each cycle and increments flush_idx.
  - On the edge that clears entry TLB_ENTRIES-1: state→IDLE, flush_idx→0, flush_done←1 for one cycle, occupancy decrements per cleared valid entry (ends at 0).
  - A flush accepted in cycle t gives flush_done in cycle t+TLB_ENTRIES+1.
- Ready signals (combinational):
  - lk_ready = IDLE && !flush_valid && (!rsp_valid || rsp_ready).
  - ld_ready = IDLE && !flush_valid.
  - flush_valid therefore has priority over same-cycle loads and lookups.
- Lookup, latency 1: a request accepted in cycle t produces rsp_valid in cycle t+1.
  - Compares lk_vaddr[VIRT_ADDR_WIDTH-1:OFF_W] against all valid entries.
  - Hit: rsp_paddr = {ppn, lk_vaddr[OFF_W-1:0]}, MEM_OK, rsp_hit=1.
  - Miss: rsp_paddr=0, MEM_ERR_ADDR, rsp_hit=0.
  - Response register holds while rsp_valid && !rsp_ready. Back-to-back throughput is 1/cycle when rsp_ready=1.
- Load, takes effect at the accepting edge. Target entry:
  - the entry already holding ld_vpn (overwrite, occupancy unchanged); else
  - the lowest-index invalid entry (occupancy+1); else
  - entry[victim_ptr], after which victim_ptr increments mod TLB_ENTRIES.
  - The victim pointer moves only on eviction.
- Simultaneous lookup and load in the same cycle: the lookup sees pre-load table contents.
- Duplicate VPNs are never created, so at most one entry can match.
- A pending response survives a flush unchanged.

Optional Feature:
- MEM_TLB_PERM_EN defined:
  - Each entry stores wr_perm from ld_wr_perm.
  - A lookup with lk_write=1 hitting an entry with wr_perm=0 returns MEM_ERR_ACCESS, rsp_hit=1, rsp_paddr=0.
  - Reads are unaffected.
- Undefined: ld_wr_perm is ignored, no storage is generated, and every hit returns MEM_OK.

Decomposition:
- memory_pkg gains:
  - tlb_state_e {TLB_IDLE, TLB_FLUSH};
  - tlb_line_t packed {valid, wr_perm, vpn, ppn};
  - default TLB_ENTRIES;
  - function page_off_w(page_size).
- Sub-module mem_tlb_match: combinational CAM compare producing a hit flag and hit index, plus a first-invalid priority encoder producing a free flag and free index.

Test Plan:
- Reset, load vpn 0x00012→ppn 0x0034, lookup vaddr 0x00012ABC → next cycle rsp_valid=1, paddr 0x0034ABC, MEM_OK, hit=1, occupancy=1.
- Lookup vaddr 0x00099000 on an empty table → MEM_ERR_ADDR, paddr 0, hit=0.
- Load 9 distinct VPNs into 8 entries → 9th evicts entry 0, victim_ptr=1, occupancy=8; lookup of the first VPN misses. Reloading an existing VPN with a new PPN overwrites it, occupancy stays 8.
- Flush with 8 valid entries at cycle 0:
  - lk_ready=0 and ld_ready=0 during cycles 1-8;
  - flush_done pulses in cycle 9; occupancy=0;
  - all lookups miss afterwards.
- Hold rsp_ready=0 for 3 cycles after a hit → rsp fields stable, lk_ready=0. Release → next lookup accepted that cycle.
- MEM_TLB_PERM_EN: load with ld_wr_perm=0, lookup lk_write=1 → MEM_ERR_ACCESS, hit=1. With lk_write=0 → MEM_OK.
- Separately, assert rst at flush cycle 4 → flush_done stays 0 and state is IDLE.
